// File: rtl/timer_ctrl.sv
// Run/pause/clear/alarm controller for a cascaded BCD seconds chain.
// Divides inpulse into one-cycle seconds ticks, sequences a synchronous
// clear of the chain and watches the chain digits against an alarm target.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | chain cleared, waiting for start
// RUN   | prescaler counting, ticks issued, alarm compare armed
// PAUSE | prescaler frozen mid-second, waiting for start to resume
// ALARM | digits reached the target; ticks stopped until stop/clear
// CLEAR | two-cycle chain reset: tick+cnt_rst, then cnt_rst alone
//
// DIV must be at least 4 so a new tick can never overlap the compare
// window of the previous one.
module timer_ctrl #(
    parameter int DIV  = 50000000,
    parameter int DIVW = 26
) (
    input  logic       inpulse,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       alarm_en,
    input  logic [3:0] alarm_ones,
    input  logic [3:0] alarm_tens,
    input  logic [3:0] dig_ones,
    input  logic [3:0] dig_tens,
    output logic       tick,
    output logic       cnt_rst,
    output logic       running,
    output logic       alarm,
    output logic [2:0] state
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_PAUSE = 3'd2;
    localparam logic [2:0] ST_ALARM = 3'd3;
    localparam logic [2:0] ST_CLEAR = 3'd4;

    localparam logic [DIVW-1:0] PRESC_TOP = DIVW'(DIV - 1);

    logic            hist_start, hist_stop, hist_clear;
    logic            press_start, press_stop, press_clear;
    logic [DIVW-1:0] presc, presc_nxt;
    logic [1:0]      clr_cnt, clr_cnt_nxt;
    logic [1:0]      pend, pend_nxt;
    logic [2:0]      state_nxt;
    logic            tick_nxt;
    logic            wrap;
    logic            match;

    assign press_start = start & ~hist_start;
    assign press_stop  = stop  & ~hist_stop;
    assign press_clear = clear & ~hist_clear;

    // pend[1] marks the cycle two after a tick, when the chain has settled
    assign wrap  = (presc == PRESC_TOP);
    assign match = pend[1] & alarm_en & (dig_ones == alarm_ones) & (dig_tens == alarm_tens);

    assign running = (state == ST_RUN);
    assign alarm   = (state == ST_ALARM);

    // Next-state, prescaler and tick decisions with clear > stop > match > start
    always_comb begin
        state_nxt   = state;
        presc_nxt   = presc;
        clr_cnt_nxt = clr_cnt;
        tick_nxt    = 1'b0;
        if (state == ST_CLEAR) begin
            presc_nxt = '0;
            case (clr_cnt)
                2'd0: begin
                    // entry straight out of rst: emit the chain-reset tick
                    tick_nxt    = 1'b1;
                    clr_cnt_nxt = 2'd1;
                end
                2'd1: clr_cnt_nxt = 2'd2;
                default: begin
                    state_nxt   = ST_IDLE;
                    clr_cnt_nxt = 2'd0;
                end
            endcase
        end else if (press_clear) begin
            state_nxt   = ST_CLEAR;
            clr_cnt_nxt = 2'd1;
            tick_nxt    = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (press_start) state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (press_stop) begin
                        state_nxt = ST_PAUSE;
                        if (wrap) presc_nxt = '0;
                    end else begin
                        presc_nxt = wrap ? '0 : presc + DIVW'(1);
                        tick_nxt  = wrap;
                        if (match) state_nxt = ST_ALARM;
                    end
                end
                ST_PAUSE: begin
                    if (press_start) state_nxt = ST_RUN;
                end
                ST_ALARM: begin
                    if (press_stop) state_nxt = ST_PAUSE;
                end
                default: begin
                    state_nxt   = ST_CLEAR;
                    clr_cnt_nxt = 2'd0;
                end
            endcase
        end
        pend_nxt = (state_nxt == ST_RUN) ? {pend[0], tick & (state == ST_RUN)} : 2'b00;
    end

    // Register state, counters, button history and the chain-facing outputs
    always_ff @(posedge inpulse) begin
        if (rst) begin
            state      <= ST_CLEAR;
            clr_cnt    <= 2'd0;
            presc      <= '0;
            pend       <= 2'b00;
            tick       <= 1'b0;
            cnt_rst    <= 1'b1;
            hist_start <= 1'b1;
            hist_stop  <= 1'b1;
            hist_clear <= 1'b1;
        end else begin
            state      <= state_nxt;
            clr_cnt    <= clr_cnt_nxt;
            presc      <= presc_nxt;
            pend       <= pend_nxt;
            tick       <= tick_nxt;
            cnt_rst    <= (state_nxt == ST_CLEAR);
            hist_start <= start;
            hist_stop  <= stop;
            hist_clear <= clear;
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl with DIV=4: directed button sequences, a BCD chain
// driven by the DUT's tick/cnt_rst, a timestamp-based reference model
// compared every cycle, and hand-computed literal checks at key cycles.
module tb_timer_ctrl;

    localparam int DIV = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ALARM = 3, M_CLEAR = 4;

    logic       inpulse = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic       alarm_en = 1'b0;
    logic [3:0] alarm_ones = 4'd0, alarm_tens = 4'd0;
    logic [3:0] ch_ones = 4'd0, ch_tens = 4'd0;
    logic       tick, cnt_rst, running, alarm;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // reference model: mode, seconds fraction, clear progress, compare timestamp
    int m_mode = M_CLEAR, m_age = 0, m_frac = 0, m_eval = -1, m_tick = 0, m_cnt_rst = 1;
    int h_start = 1, h_stop = 1, h_clear = 1, cyc = 0;
    int ps, pp, pc, nm, nt, hit;

    timer_ctrl #(.DIV(DIV), .DIVW(3)) dut (
        .inpulse(inpulse), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .alarm_en(alarm_en), .alarm_ones(alarm_ones), .alarm_tens(alarm_tens),
        .dig_ones(ch_ones), .dig_tens(ch_tens),
        .tick(tick), .cnt_rst(cnt_rst), .running(running), .alarm(alarm), .state(state)
    );

    always #5 inpulse = ~inpulse;

    // BCD seconds chain clocked by the DUT's tick, reset by cnt_rst
    always @(posedge inpulse) begin
        if (tick) begin
            if (cnt_rst) begin
                ch_ones <= 4'd0;
                ch_tens <= 4'd0;
            end else if (ch_ones == 4'd9) begin
                ch_ones <= 4'd0;
                ch_tens <= (ch_tens == 4'd9) ? 4'd0 : ch_tens + 4'd1;
            end else begin
                ch_ones <= ch_ones + 4'd1;
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // model step on every rising edge
    initial begin
        forever begin
            @(posedge inpulse);
            if (rst) begin
                m_mode = M_CLEAR; m_age = 0; m_frac = 0; m_eval = -1;
                m_tick = 0; m_cnt_rst = 1;
                h_start = 1; h_stop = 1; h_clear = 1;
            end else begin
                ps = (start && !h_start) ? 1 : 0;
                pp = (stop  && !h_stop)  ? 1 : 0;
                pc = (clear && !h_clear) ? 1 : 0;
                h_start = int'(start); h_stop = int'(stop); h_clear = int'(clear);
                hit = (cyc == m_eval && alarm_en && ch_ones == alarm_ones && ch_tens == alarm_tens) ? 1 : 0;
                nm = m_mode;
                nt = 0;
                if (m_mode == M_CLEAR) begin
                    m_frac = 0;
                    if (m_age == 0) begin m_age = 1; nt = 1; end
                    else if (m_age == 1) m_age = 2;
                    else begin nm = M_IDLE; m_age = 0; end
                end else if (pc != 0) begin
                    nm = M_CLEAR; m_age = 1; nt = 1;
                end else if (m_mode == M_IDLE || m_mode == M_PAUSE) begin
                    if (ps != 0) nm = M_RUN;
                end else if (m_mode == M_ALARM) begin
                    if (pp != 0) nm = M_PAUSE;
                end else begin
                    if (pp != 0) begin
                        nm = M_PAUSE;
                        if (m_frac == DIV - 1) m_frac = 0;
                    end else begin
                        nt = (m_frac == DIV - 1) ? 1 : 0;
                        m_frac = (m_frac + 1) % DIV;
                        if (hit != 0) nm = M_ALARM;
                    end
                end
                if (m_mode == M_RUN && m_tick != 0) m_eval = cyc + 2;
                if (nm != M_RUN) m_eval = -1;
                m_mode = nm;
                m_tick = nt;
                m_cnt_rst = (nm == M_CLEAR) ? 1 : 0;
            end
            cyc++;
        end
    end

    // compare DUT against the model mid-cycle
    initial begin
        forever begin
            @(negedge inpulse);
            if (chk_en) begin
                chk("cmp_state",   state,   m_mode);
                chk("cmp_tick",    tick,    m_tick);
                chk("cmp_cnt_rst", cnt_rst, m_cnt_rst);
                chk("cmp_running", running, (m_mode == M_RUN) ? 1 : 0);
                chk("cmp_alarm",   alarm,   (m_mode == M_ALARM) ? 1 : 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic adv(input int n);
        repeat (n) @(posedge inpulse);
        #1;
    endtask

    task automatic do_clear();
        adv(1); clear = 1'b1;
        adv(1); clear = 1'b0;
        adv(2);
        chk("clr_idle", state, M_IDLE);
    endtask

    initial begin
        adv(1);
        chk_en = 1'b1;
        adv(2);
        // 1: release reset, CLEAR sequence then IDLE
        rst = 1'b0;
        chk("t1_c0_state", state, 4); chk("t1_c0_tick", tick, 0); chk("t1_c0_crst", cnt_rst, 1);
        adv(1); chk("t1_c1_tick", tick, 1); chk("t1_c1_crst", cnt_rst, 1);
        adv(1); chk("t1_c2_tick", tick, 0); chk("t1_c2_crst", cnt_rst, 1); chk("t1_c2_state", state, 4);
        adv(1); chk("t1_c3_state", state, 0); chk("t1_c3_crst", cnt_rst, 0);

        // 2: start press, ticks at 5, 9, 13
        adv(1); start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            adv(1);
            if (c == 1) begin
                start = 1'b0;
                chk("t2_state", state, 1); chk("t2_running", running, 1);
            end
            chk("t2_tick", tick, (c == 5 || c == 9 || c == 13) ? 1 : 0);
        end

        // 3: pause at 3, resume at 10, next tick at 13
        do_clear();
        adv(1); start = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            adv(1);
            if (c == 1)  start = 1'b0;
            if (c == 3)  stop  = 1'b1;
            if (c == 4)  begin stop = 1'b0; chk("t3_pause", state, 2); end
            if (c == 10) start = 1'b1;
            if (c == 11) begin start = 1'b0; chk("t3_resume", state, 1); end
            chk("t3_tick", tick, (c == 13) ? 1 : 0);
        end

        // 4: alarm at digits 03, acknowledged by stop
        do_clear();
        alarm_en = 1'b1; alarm_ones = 4'd3; alarm_tens = 4'd0;
        adv(1); start = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            adv(1);
            if (c == 1)  start = 1'b0;
            if (c == 15) chk("t4_pre", state, 1);
            if (c == 16) begin chk("t4_state", state, 3); chk("t4_alarm", alarm, 1); end
            if (c == 22) chk("t4_hold", state, 3);
            if (c == 23) stop = 1'b1;
            if (c == 24) begin stop = 1'b0; chk("t4_ack", state, 2); chk("t4_ack_alarm", alarm, 0); end
            chk("t4_tick", tick, (c == 5 || c == 9 || c == 13) ? 1 : 0);
        end
        alarm_en = 1'b0;

        // 5a: clear and start together in IDLE
        do_clear();
        adv(1); clear = 1'b1; start = 1'b1;
        adv(1); clear = 1'b0; start = 1'b0;
        chk("t5a_state", state, 4); chk("t5a_tick", tick, 1);
        adv(2); chk("t5a_idle", state, 0);
        // 5b: stop and clear together in RUN
        adv(1); start = 1'b1;
        adv(1); start = 1'b0;
        adv(1); stop = 1'b1; clear = 1'b1;
        adv(1); stop = 1'b0; clear = 1'b0;
        chk("t5b_state", state, 4);
        adv(2); chk("t5b_idle", state, 0);
        // 5c: stop in the wrap cycle suppresses the tick; 6: rst mid-run with start held
        adv(1); start = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            adv(1);
            if (c == 1) start = 1'b0;
            if (c == 4) stop = 1'b1;
            if (c == 5) begin stop = 1'b0; chk("t5c_state", state, 2); end
            if (c == 6) start = 1'b1;
            if (c == 7) start = 1'b0;
            if (c <= 13) chk("t5c_tick", tick, (c == 11) ? 1 : 0);
            if (c == 14) begin rst = 1'b1; start = 1'b1; end
            if (c == 15) begin
                chk("t6_tick", tick, 0); chk("t6_crst", cnt_rst, 1); chk("t6_state", state, 4);
            end
            if (c == 16) rst = 1'b0;
            if (c >= 19) begin chk("t6_norun", state, 0); chk("t6_running", running, 0); end
        end
        start = 1'b0;
        adv(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
